// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 byte transmitter with timing/parity parameters, watchdog, ACK check and retry
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int INHIBIT_US  = 120,
  parameter int TIMEOUT_US  = 2000,
  parameter int MAX_RETRIES = 2,
  parameter bit ODD_PARITY  = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_PS2_IN,
  output logic       CLK_PS2_OUT_EN,
  input  logic       DATA_PS2_IN,
  output logic       DATA_PS2_OUT,
  output logic       DATA_PS2_OUT_EN,
  input  logic       SEND_BYTE,
  input  logic [7:0] BYTE_TO_SEND,
  output logic       BUSY,
  output logic       BYTE_SENT,
  output logic       SEND_ERROR,
  output logic [1:0] ERROR_CODE
);
  localparam int CPU         = CLK_FREQ_HZ / 1_000_000;
  localparam int INHIBIT_CYC = CPU * INHIBIT_US;
  localparam int TIMEOUT_CYC = CPU * TIMEOUT_US;
  localparam int MAXC        = INHIBIT_CYC > TIMEOUT_CYC ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int CW          = $clog2(MAXC + 1);
  localparam int RW          = MAX_RETRIES > 0 ? $clog2(MAX_RETRIES + 1) : 1;
  typedef enum logic [3:0] {IDLE, INHIBIT, REQ, START, DATA, PARITY, STOP, ACK, WAIT_IDLE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [RW-1:0] retries, retries_n;
  logic [2:0] idx, idx_n;
  logic [7:0] byte_q, byte_n;
  logic [1:0] err_n;
  logic sent_n, fail_n;
  logic clk_s1, clk_s, clk_d, dat_s1, dat_s;
  logic fe, wd, tout, nack, par;
  assign fe   = clk_d & ~clk_s;
  assign wd   = !(state inside {IDLE, INHIBIT, REQ});
  assign tout = wd && cnt == CW'(TIMEOUT_CYC) && !fe;
  assign nack = state == ACK && fe && dat_s;
  assign par  = ODD_PARITY ? ~^byte_q : ^byte_q;
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    byte_n    = byte_q;
    retries_n = retries;
    err_n     = ERROR_CODE;
    sent_n    = 1'b0;
    fail_n    = 1'b0;
    unique case (state)
      IDLE:      if (SEND_BYTE) begin
                   state_n   = INHIBIT;
                   byte_n    = BYTE_TO_SEND;
                   retries_n = RW'(MAX_RETRIES);
                   err_n     = 2'b00;
                 end
      INHIBIT:   if (cnt == CW'(INHIBIT_CYC - 1)) state_n = REQ;
      REQ:       state_n = START;
      START:     if (fe) begin
                   state_n = DATA;
                   idx_n   = 3'd0;
                 end
      DATA:      if (fe) begin
                   idx_n   = idx + 1'b1;
                   state_n = &idx ? PARITY : DATA;
                 end
      PARITY:    if (fe) state_n = STOP;
      STOP:      if (fe) state_n = ACK;
      ACK:       if (fe && !dat_s) state_n = WAIT_IDLE;
      WAIT_IDLE: if (clk_s && dat_s) begin
                   state_n = IDLE;
                   sent_n  = 1'b1;
                 end
      default:   state_n = IDLE;
    endcase
    // a failed attempt overrides whatever the protocol step chose
    if (tout || nack) begin
      err_n = tout ? 2'b01 : 2'b10;
      if (|retries) begin
        retries_n = retries - 1'b1;
        state_n   = INHIBIT;
      end else begin
        state_n = IDLE;
        fail_n  = 1'b1;
      end
    end
  end
  assign cnt_n = (state_n != state || (wd && fe) || state == IDLE) ? '0 : cnt + 1'b1;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      {clk_s1, clk_s, clk_d} <= 3'b111;
      {dat_s1, dat_s}        <= 2'b11;
      state           <= IDLE;
      cnt             <= '0;
      retries         <= RW'(MAX_RETRIES);
      idx             <= 3'd0;
      byte_q          <= 8'd0;
      CLK_PS2_OUT_EN  <= 1'b0;
      DATA_PS2_OUT_EN <= 1'b0;
      DATA_PS2_OUT    <= 1'b0;
      BUSY            <= 1'b0;
      BYTE_SENT       <= 1'b0;
      SEND_ERROR      <= 1'b0;
      ERROR_CODE      <= 2'b00;
    end else begin
      {clk_s1, clk_s, clk_d} <= {CLK_PS2_IN, clk_s1, clk_s};
      {dat_s1, dat_s}        <= {DATA_PS2_IN, dat_s1};
      state           <= state_n;
      cnt             <= cnt_n;
      retries         <= retries_n;
      idx             <= idx_n;
      byte_q          <= byte_n;
      CLK_PS2_OUT_EN  <= state inside {INHIBIT, REQ};
      DATA_PS2_OUT_EN <= state inside {REQ, START, DATA, PARITY, STOP};
      DATA_PS2_OUT    <= state == DATA ? byte_q[idx] : state == PARITY ? par : state == STOP;
      BUSY            <= state != IDLE;
      BYTE_SENT       <= sent_n;
      SEND_ERROR      <= fail_n;
      ERROR_CODE      <= err_n;
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: device-side BFM plus frame/outcome model for ps2_host_tx
module tb_ps2_host_tx;
  localparam int H  = 20;
  localparam int TO = 500;
  typedef struct {bit err; logic [1:0] code; int att;} exp_t;
  logic CLK = 1'b0, RESET = 1'b1;
  always #5 CLK = ~CLK;
  logic dev_clk = 1'b1, dev_dat = 1'b1, send = 1'b0, d_send = 1'b0;
  logic [7:0] byte_in = 8'd0;
  logic m_cen, m_den, m_dout, m_busy, m_sent, m_serr;
  logic e_cen, e_den, e_dout, e_busy, e_sent, e_serr;
  logic d_cen, d_den, d_dout, d_busy, d_sent, d_serr;
  logic [1:0] m_code, e_code, d_code;
  logic clk_pad, m_dat, e_dat, d_clk, d_dat;
  int checks = 0, errors = 0, att = 0;
  logic cen_q = 1'b0;
  exp_t exp_q[$];
  logic [10:0] fm, fe;
  assign clk_pad = dev_clk & ~m_cen & ~e_cen;
  assign m_dat   = dev_dat & ~(m_den & ~m_dout);
  assign e_dat   = dev_dat & ~(e_den & ~e_dout);
  assign d_clk   = ~d_cen;
  assign d_dat   = ~(d_den & ~d_dout);

  ps2_host_tx #(.CLK_FREQ_HZ(10_000_000), .INHIBIT_US(12), .TIMEOUT_US(50), .MAX_RETRIES(2), .ODD_PARITY(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .CLK_PS2_IN(clk_pad), .CLK_PS2_OUT_EN(m_cen), .DATA_PS2_IN(m_dat),
    .DATA_PS2_OUT(m_dout), .DATA_PS2_OUT_EN(m_den), .SEND_BYTE(send), .BYTE_TO_SEND(byte_in),
    .BUSY(m_busy), .BYTE_SENT(m_sent), .SEND_ERROR(m_serr), .ERROR_CODE(m_code));
  ps2_host_tx #(.CLK_FREQ_HZ(10_000_000), .INHIBIT_US(12), .TIMEOUT_US(50), .MAX_RETRIES(2), .ODD_PARITY(1'b0)) dut_e (
    .CLK(CLK), .RESET(RESET), .CLK_PS2_IN(clk_pad), .CLK_PS2_OUT_EN(e_cen), .DATA_PS2_IN(e_dat),
    .DATA_PS2_OUT(e_dout), .DATA_PS2_OUT_EN(e_den), .SEND_BYTE(send), .BYTE_TO_SEND(byte_in),
    .BUSY(e_busy), .BYTE_SENT(e_sent), .SEND_ERROR(e_serr), .ERROR_CODE(e_code));
  ps2_host_tx dut_d (
    .CLK(CLK), .RESET(RESET), .CLK_PS2_IN(d_clk), .CLK_PS2_OUT_EN(d_cen), .DATA_PS2_IN(d_dat),
    .DATA_PS2_OUT(d_dout), .DATA_PS2_OUT_EN(d_den), .SEND_BYTE(d_send), .BYTE_TO_SEND(byte_in),
    .BUSY(d_busy), .BYTE_SENT(d_sent), .SEND_ERROR(d_serr), .ERROR_CODE(d_code));

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, a, x);
    end
  endtask

  // frame as the device sees it: {stop, parity, byte, start}
  function automatic logic [10:0] frame(input logic [7:0] b, input bit odd);
    bit p;
    p = odd ? ($countones(b) % 2 == 0) : ($countones(b) % 2 == 1);
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    byte_in = b;
    send = 1'b1;
    @(negedge CLK);
    send = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 6000 && exp_q.size() != 0; i++) @(negedge CLK);
    check("done_bound", exp_q.size(), 0);
  endtask

  task automatic device_frame(input bit ack, input int rst_at, input bit mid, output logic [10:0] om, output logic [10:0] oe);
    om = '0;
    oe = '0;
    for (int i = 0; i < 3000 && !m_cen; i++) @(negedge CLK);
    check("rts_inhibit", m_cen, 1);
    for (int i = 0; i < 3000 && m_cen; i++) @(negedge CLK);
    check("rts_release", m_cen, 0);
    repeat (10) @(negedge CLK);
    om[0] = m_dat;
    oe[0] = e_dat;
    for (int k = 0; k < 12; k++) begin
      dev_clk = 1'b0;
      if (mid && k == 3) begin
        byte_in = 8'h00;
        send = 1'b1;
        @(negedge CLK);
        send = 1'b0;
      end
      repeat (H) @(negedge CLK);
      if (k < 10) begin
        om[k+1] = m_dat;
        oe[k+1] = e_dat;
      end
      if (k == 10) dev_dat = ack ? 1'b0 : 1'b1;
      if (k == rst_at) begin
        RESET = 1'b1;
        @(negedge CLK);
        check("midframe_reset_m", {m_cen, m_den, m_dout, m_busy, m_sent, m_serr, m_code}, 0);
        check("midframe_reset_e", {e_cen, e_den, e_dout, e_busy, e_sent, e_serr, e_code}, 0);
        @(negedge CLK);
        RESET = 1'b0;
        dev_clk = 1'b1;
        return;
      end
      dev_clk = 1'b1;
      repeat (H) @(negedge CLK);
    end
    dev_dat = 1'b1;
  endtask

  always @(negedge CLK) begin
    if (RESET) att = 0;
    else begin
      if (m_cen && !cen_q) att++;
      if (m_cen || m_den) check("busy_while_driving", m_busy, 1);
      if (m_sent || m_serr) begin
        if (exp_q.size() == 0) check("unexpected_done", {m_sent, m_serr}, 2'b00);
        else begin
          exp_t x;
          x = exp_q.pop_front();
          check("done_error", m_serr, x.err);
          check("done_sent", m_sent, !x.err);
          check("done_code", m_code, x.code);
          check("attempts", att, x.att);
          check("even_outcome", {e_sent, e_serr, e_code}, {m_sent, m_serr, m_code});
          att = 0;
        end
      end
    end
    cen_q = m_cen;
  end

  initial begin
    int n;
    repeat (5) @(negedge CLK);
    check("reset_m", {m_cen, m_den, m_dout, m_busy, m_sent, m_serr, m_code}, 0);
    check("reset_d", {d_cen, d_den, d_dout, d_busy, d_sent, d_serr, d_code}, 0);
    RESET = 1'b0;
    @(negedge CLK);
    d_send = 1'b1;
    @(negedge CLK);
    d_send = 1'b0;
    for (int i = 0; i < 5 && !d_cen; i++) @(negedge CLK);
    n = 0;
    while (d_cen && !d_den && n < 7000) begin
      n++;
      @(negedge CLK);
    end
    check("inhibit_cycles", n, 6000);
    check("req_cycle", {d_cen, d_den, d_dout}, 3'b110);
    @(negedge CLK);
    check("clk_release", {d_cen, d_den, d_dout}, 3'b010);
    check("d_busy", d_busy, 1);

    send_byte(8'hF4);
    exp_q.push_back('{1'b0, 2'b00, 1});
    device_frame(1'b1, -1, 1'b0, fm, fe);
    check("f4_frame", fm, frame(8'hF4, 1'b1));
    check("f4_literal", fm, 11'b10111101000);
    check("f4_even", fe, frame(8'hF4, 1'b0));
    wait_done();
    check("f4_code", m_code, 2'b00);

    send_byte(8'hFF);
    exp_q.push_back('{1'b0, 2'b00, 1});
    device_frame(1'b1, -1, 1'b1, fm, fe);
    check("ff_frame", fm, frame(8'hFF, 1'b1));
    check("ff_even", fe, frame(8'hFF, 1'b0));
    check("ff_even_literal", fe, 11'b10111111110);
    wait_done();
    repeat (200) @(negedge CLK);
    check("ignored_send", m_busy, 0);

    send_byte(8'h5A);
    exp_q.push_back('{1'b1, 2'b10, 3});
    repeat (3) begin
      device_frame(1'b0, -1, 1'b0, fm, fe);
      check("nack_frame", fm, frame(8'h5A, 1'b1));
    end
    wait_done();
    @(negedge CLK);
    check("nack_code", m_code, 2'b10);
    check("nack_release", {m_cen, m_den, m_busy}, 0);

    send_byte(8'h33);
    exp_q.push_back('{1'b1, 2'b01, 3});
    for (int i = 0; i < 300 && !m_cen; i++) @(negedge CLK);
    for (int i = 0; i < 300 && m_cen; i++) @(negedge CLK);
    n = 0;
    while (!m_cen && n < 2 * TO) begin
      n++;
      @(negedge CLK);
    end
    check("timeout_gap", n >= TO && n <= TO + 4, 1);
    wait_done();
    @(negedge CLK);
    check("timeout_code", m_code, 2'b01);
    check("timeout_release", {m_cen, m_den, m_busy}, 0);

    send_byte(8'h81);
    device_frame(1'b1, 4, 1'b0, fm, fe);
    repeat (5) @(negedge CLK);
    send_byte(8'hED);
    exp_q.push_back('{1'b0, 2'b00, 1});
    device_frame(1'b1, -1, 1'b0, fm, fe);
    check("ed_frame", fm, frame(8'hED, 1'b1));
    check("ed_literal", fm, 11'b11111011010);
    wait_done();
    repeat (5) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
